histogram_accumulator: RTL and testbench

Parametrised successor to the single-channel radiation histogram. Bins incoming samples by a programmable right-shift and keeps saturating per-bin counters in on-chip RAM, with a pipelined read-modify-write and same-bin forwarding. Adds a host read port with optional clear-on-read, a global clear sweep, a sample total and a sticky overflow flag. Sits between the radiation sample front-end and the host register interface.

---
 rtl/histogram_accumulator.sv | 106 ++++++++++
 tb/tb_histogram_accumulator.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/histogram_accumulator.sv
// histogram_accumulator: saturating per-bin sample histogram with host read port and clear sweep
//   clk, reset                : clock, synchronous active-high reset
//   valueValid/valueReady     : sample handshake; radiationValue is binned by >> BIN_SHIFT
//   readRequest/readReady     : host read handshake; readAddress selects the bin, readClear zeroes it
//   readValid/readData        : read response two cycles after accept; readData holds until the next one
//   clearAll/busy             : start / in-progress of the one-bin-per-cycle zeroing sweep
//   totalCount, overflowFlag  : saturating accepted-sample total, sticky bin-saturation flag
module histogram_accumulator #(
    parameter int VALUE_WIDTH = 10,
    parameter int BIN_SHIFT   = 0,
    parameter int COUNT_WIDTH = 16,
    parameter int TOTAL_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             valueValid,
    output logic                             valueReady,
    input  logic [VALUE_WIDTH-1:0]           radiationValue,
    input  logic                             readRequest,
    output logic                             readReady,
    input  logic [VALUE_WIDTH-BIN_SHIFT-1:0] readAddress,
    input  logic                             readClear,
    output logic                             readValid,
    output logic [COUNT_WIDTH-1:0]           readData,
    input  logic                             clearAll,
    output logic                             busy,
    output logic [TOTAL_WIDTH-1:0]           totalCount,
    output logic                             overflowFlag
);
    localparam int BW = VALUE_WIDTH - BIN_SHIFT;
    localparam int NUM_BINS = 1 << BW;
    typedef enum logic {CLEAR, RUN} state_t;
    state_t state_q, state_d;
    logic [BW-1:0] idx_q, idx_d;
    logic [COUNT_WIDTH-1:0] mem [NUM_BINS];
    logic s1_q, s2_q, r1_q, rvalid_q, rc1_q, rc2_q, ovf_q, ovf_d;
    logic [BW-1:0] s1_bin_q, s2_bin_q, r1_addr_q, r2_addr_q, raddr, wa;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, inc, rdat, rd_d, rdata_q, wd;
    logic [TOTAL_WIDTH-1:0] total_q, total_d;
    logic run, rd_acc, ing_acc, sat, we;

    always_comb begin
        run = state_q == RUN;
        readReady = run && !s1_q && !s2_q;
        rd_acc = readRequest && readReady;
        valueReady = run && !r1_q && !rvalid_q && !rd_acc;
        ing_acc = valueValid && valueReady;
        state_d = clearAll ? CLEAR : (!run && &idx_q) ? RUN : state_q;
        idx_d = (clearAll || run) ? '0 : idx_q + 1'b1;
        // one shared read port: a read in flight never overlaps an ingest in stage 1
        raddr = r1_q ? r1_addr_q : s1_bin_q;
        rdat = mem[raddr];
        sat = &cnt_q;
        inc = sat ? cnt_q : cnt_q + 1'b1;
        // same-bin forwarding: the count being written this cycle replaces the stale RAM word
        cnt_d = (s2_q && s2_bin_q == s1_bin_q) ? inc : rdat;
        // back-to-back reads of a bin whose clear is still pending must see zero
        rd_d = (rvalid_q && rc2_q && r2_addr_q == r1_addr_q) ? '0 : rdat;
        we = !run || s2_q || (rvalid_q && rc2_q);
        wa = !run ? idx_q : s2_q ? s2_bin_q : r2_addr_q;
        wd = (run && s2_q) ? inc : '0;
        total_d = clearAll ? '0 : (s2_q && !(&total_q)) ? total_q + 1'b1 : total_q;
        ovf_d = clearAll ? 1'b0 : ovf_q | (s2_q & sat);
    end

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            idx_q <= '0;
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            r1_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q <= '0;
            total_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            s1_q <= ing_acc && !clearAll;
            s2_q <= s1_q && !clearAll;
            r1_q <= rd_acc && !clearAll;
            rvalid_q <= r1_q && !clearAll;
            if (r1_q && !clearAll) rdata_q <= rd_d;
            total_q <= total_d;
            ovf_q <= ovf_d;
        end
        s1_bin_q <= radiationValue[VALUE_WIDTH-1:BIN_SHIFT];
        s2_bin_q <= s1_bin_q;
        cnt_q <= cnt_d;
        r1_addr_q <= readAddress;
        r2_addr_q <= r1_addr_q;
        rc1_q <= readClear;
        rc2_q <= rc1_q;
    end

    assign readValid = rvalid_q;
    assign readData = rdata_q;
    assign busy = !run;
    assign totalCount = total_q;
    assign overflowFlag = ovf_q;
endmodule

// File: tb/tb_histogram_accumulator.sv
// tb_histogram_accumulator: randomized scoreboard bench for histogram_accumulator
module tb_histogram_accumulator;
    localparam int VW = 10, BS = 2, CW = 5, TW = 32;
    localparam int BW = VW - BS, NB = 1 << BW, MAXC = (1 << CW) - 1;
    logic clk = 1'b0, reset = 1'b1;
    logic valueValid = 1'b0, readRequest = 1'b0, readClear = 1'b0, clearAll = 1'b0;
    logic [VW-1:0] radiationValue = '0;
    logic [BW-1:0] readAddress = '0;
    logic valueReady, readReady, readValid, busy, overflowFlag;
    logic [CW-1:0] readData;
    logic [TW-1:0] totalCount;

    histogram_accumulator #(.VALUE_WIDTH(VW), .BIN_SHIFT(BS), .COUNT_WIDTH(CW), .TOTAL_WIDTH(TW)) dut (
        .clk(clk), .reset(reset), .valueValid(valueValid), .valueReady(valueReady),
        .radiationValue(radiationValue), .readRequest(readRequest), .readReady(readReady),
        .readAddress(readAddress), .readClear(readClear), .readValid(readValid), .readData(readData),
        .clearAll(clearAll), .busy(busy), .totalCount(totalCount), .overflowFlag(overflowFlag)
    );

    always #5 clk = ~clk;

    typedef struct { int data; int cyc; } exp_t;
    exp_t q[$];
    exp_t e_mon;
    int errors = 0, checks = 0, cyc = 0;
    int model [NB];
    longint m_total = 0;
    bit m_ovf = 0, run = 0, ing1 = 0, ing2 = 0, rd1 = 0, rd2 = 0, b = 0, rst_v = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (readValid && !reset) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL readValid_unexpected: got data %0d, expected no response", readData);
            end else begin
                e_mon = q.pop_front();
                check("readData", longint'(readData), e_mon.data);
                check("readLatency", e_mon.cyc == cyc, 1);
            end
        end
    end

    task automatic clear_model();
        foreach (model[i]) model[i] = 0;
        m_total = 0;
        m_ovf = 0;
        run = 0;
        {ing1, ing2, rd1, rd2} = '0;
    endtask

    // one clock cycle: drive at negedge, predict handshakes and update the reference histogram
    task automatic step(bit vv, int val, bit rr, int addr, bit clr, bit ca);
        bit exp_rr, exp_vr, va, ra;
        int bn;
        @(negedge clk);
        reset = rst_v;
        valueValid = vv;
        radiationValue = VW'(val);
        readRequest = rr;
        readAddress = BW'(addr);
        readClear = clr;
        clearAll = ca;
        #1;
        b = busy;
        exp_rr = run && !ing1 && !ing2;
        exp_vr = run && !rd1 && !rd2 && !(rr && exp_rr);
        if (run) begin
            check("readReady", longint'(readReady), exp_rr);
            check("valueReady", longint'(valueReady), exp_vr);
        end
        va = vv && exp_vr;
        ra = rr && exp_rr;
        ing2 = ing1; ing1 = va; rd2 = rd1; rd1 = ra;
        if (ca) clear_model();
        else begin
            if (va) begin
                bn = (val % (1 << VW)) / (1 << BS);
                if (model[bn] == MAXC) m_ovf = 1; else model[bn]++;
                m_total++;
            end
            if (ra) begin
                q.push_back('{model[addr], cyc + 2});
                if (clr) model[addr] = 0;
            end
        end
    endtask

    task automatic idle(int n);
        repeat (n) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic sweep(int exp_n);
        int n = 0;
        do begin
            step(0, 0, 0, 0, 0, 0);
            if (b) n++;
        end while (b && n < 4 * NB);
        check("busy_cycles", n, exp_n);
        run = 1;
        {ing1, ing2, rd1, rd2} = '0;
    endtask

    task automatic do_reset();
        clear_model();
        rst_v = 1;
        idle(3);
        check("rst_valueReady", longint'(valueReady), 0);
        check("rst_readReady", longint'(readReady), 0);
        check("rst_readValid", longint'(readValid), 0);
        check("rst_readData", longint'(readData), 0);
        check("rst_busy", longint'(busy), 1);
        check("rst_totalCount", longint'(totalCount), 0);
        check("rst_overflow", longint'(overflowFlag), 0);
        rst_v = 0;
    endtask

    task automatic rd(int a, bit c);
        int n = 0;
        do begin
            step(0, 0, 1, a, c, 0);
            n++;
        end while (!rd1 && n < 10);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            idle(1);
            n++;
        end
        check("queue_drained", q.size(), 0);
    endtask

    task automatic check_totals();
        idle(3);
        check("totalCount", longint'(totalCount), m_total);
        check("overflowFlag", longint'(overflowFlag), m_ovf);
    endtask

    initial begin
        do_reset();
        sweep(NB);
        for (int i = 0; i < 4; i++) rd(i * 37, 0);
        drain();
        for (int i = 0; i < 8; i++) step(1, 20 + i % 4, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(1, 21, 0, 0, 0, 0);
            idle(i % 3);
        end
        rd(5, 0);
        drain();
        for (int i = 0; i < 3000; i++)
            step($urandom % 8 != 0, int'($urandom % (1 << VW)), $urandom % 16 == 0,
                 int'($urandom % NB), 1'($urandom), 0);
        drain();
        check_totals();
        for (int a = 0; a < NB; a++) rd(a, 0);
        drain();
        rd(7, 1);
        for (int i = 0; i < 4; i++) step(1, 28 + i, 0, 0, 0, 0);
        rd(7, 1);
        rd(7, 0);
        rd(6, 0);
        drain();
        for (int i = 0; i < 40; i++) step(1, 36 + i % 4, 0, 0, 0, 0);
        check_totals();
        rd(9, 0);
        drain();
        for (int i = 0; i < 10; i++) step(1, int'($urandom % (1 << VW)), 0, 0, 0, 0);
        step(1, 5, 0, 0, 0, 1);
        idle(50);
        step(0, 0, 0, 0, 0, 1);
        sweep(NB);
        check_totals();
        for (int a = 0; a < NB; a++) rd(a, 0);
        drain();
        for (int i = 0; i < 3; i++) step(1, 16, 0, 0, 0, 0);
        rd(4, 0);
        drain();
        for (int i = 0; i < 5; i++) step(1, 17, 0, 0, 0, 0);
        do_reset();
        sweep(NB);
        rd(4, 0);
        drain();
        check_totals();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
